// File: rtl/timer_irq_ctrl_pkg.sv
// Shared constants for the memory-mapped timer / IRQ controller:
// register offsets, TCON bit positions and the default window base.
package timer_irq_ctrl_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_CYC     = 32'h0000_000C;
  localparam logic [31:0] OFF_PEND    = 32'h0000_0010;
  localparam logic [31:0] WINDOW_SIZE = 32'h0000_0014;

  localparam int EN_BIT = 0;
  localparam int IE_BIT = 1;
  localparam int ST_BIT = 2;

endpackage

// File: rtl/timer_irq_ctrl_prescaler.sv
// Prescaler for the timer: counts enabled cycles 0..PRESCALE-1 and
// flags a tick on the last one. Holds its phase while disabled.
module timer_prescaler
  import timer_irq_ctrl_pkg::*;
#(
  parameter int PRESCALE   = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: a clear takes priority, otherwise advance and wrap on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped timer with reload, sticky interrupt status and a
// free-running cycle counter. Sits beside data memory on the MEM-stage bus.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          PRESCALE   = 1,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] off;
  logic        wr, wr_th, wr_tl, wr_tcon;
  logic        tick, overflow;
  logic [31:0] th_q, th_d, tl_q, tl_d, cyc_q, cyc_d;
  logic        en_q, en_d, ie_q, ie_d, st_q, st_d;
  logic        unused_bits;

  // rdata does not depend on mem_read; the top-level mux qualifies it.
  assign unused_bits = mem_read;

  // Addresses below the base wrap to large offsets and miss naturally.
  assign off     = addr - BASE_ADDR;
  assign hit     = (off < WINDOW_SIZE) && (off[1:0] == 2'b00);
  assign wr      = hit && mem_write;
  assign wr_th   = wr && (off == OFF_TH);
  assign wr_tl   = wr && (off == OFF_TL);
  assign wr_tcon = wr && (off == OFF_TCON);

  assign overflow = tick && (tl_q == 32'hFFFF_FFFF);
  assign irq      = st_q;

  timer_prescaler #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en_q),
    .clr   (wr_tl),
    .tick  (tick)
  );

  // Read mux: always reflects pre-edge register state.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_TH:   rdata = th_q;
        OFF_TL:   rdata = tl_q;
        OFF_TCON: rdata = {29'b0, st_q, ie_q, en_q};
        OFF_CYC:  rdata = cyc_q;
        OFF_PEND: rdata = {31'b0, st_q};
        default:  rdata = '0;
      endcase
    end
  end

  // Next-state: TL write beats a tick; overflow with pre-write IE beats an ST clear.
  always_comb begin
    th_d  = wr_th ? wdata : th_q;
    cyc_d = cyc_q + 32'd1;

    tl_d = tl_q;
    if (wr_tl)         tl_d = wdata;
    else if (overflow) tl_d = th_q;
    else if (tick)     tl_d = tl_q + 32'd1;

    en_d = wr_tcon ? wdata[EN_BIT] : en_q;
    ie_d = wr_tcon ? wdata[IE_BIT] : ie_q;
    st_d = wr_tcon ? wdata[ST_BIT] : st_q;
    if (overflow && ie_q) st_d = 1'b1;
  end

  // Register file with synchronous reset overriding any write or count.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q  <= '0;
      tl_q  <= '0;
      cyc_q <= '0;
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      st_q  <= 1'b0;
    end else begin
      th_q  <= th_d;
      tl_q  <= tl_d;
      cyc_q <= cyc_d;
      en_q  <= en_d;
      ie_q  <= ie_d;
      st_q  <= st_d;
    end
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Memory-mapped timer and interrupt-request controller on the CPU data bus, beside data memory.
- The MEM stage reads and writes its registers through the normal load and store path.
- It produces the level-sensitive IRQ consumed by the ID-stage control decoder, which gates IRQ with Supervised and redirects PC to the interrupt vector.
- It also provides a free-running cycle counter for software timing.

Parameters:
- BASE_ADDR, 32'h4000_0000, word-aligned base of the 5-register window.
- PRESCALE, 1, timer increments once every PRESCALE enabled cycles. Legal range ≥ 1.
- PRESCALE_W, 16, width of the internal prescaler counter. Must hold PRESCALE-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the MEM stage (ALU result).
- mem_read  in  1  load in MEM stage.
- mem_write  in  1  store in MEM stage.
- wdata  in  32  store data.
- hit  out  1  addr is inside the window and word-aligned. Combinational. The top level uses it to mux rdata and to suppress the data-memory write.
- rdata  out  32  read data. Combinational from addr and current register state. 0 when not hit.
- irq  out  1  interrupt request to the control decoder; equals TCON.status.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: R/W bits [2:0]; upper bits read 0.
    - bit0 EN: count enable.
    - bit1 IE: interrupt enable.
    - bit2 ST: status, sticky.
  - 0x0C CYC: cycle counter, read-only; writes ignored.
  - 0x10 PEND: read-only mirror of irq in bit0.
  - Offsets ≥ 0x14 and unaligned addresses: hit=0.
- Reset: TH, TL, TCON, CYC and the prescaler all go to 0, so irq=0. Reset overrides every same-cycle write or count. Asserting reset mid-count discards all progress.
- CYC increments by 1 every cycle after reset and wraps from 0xFFFF_FFFF to 0. It is unaffected by EN.
- Prescaler:
  - When EN=1 it counts 0..PRESCALE-1, then wraps to 0.
  - A tick occurs in the cycle the prescaler equals PRESCALE-1.
  - With PRESCALE=1, every EN cycle is a tick.
  - When EN=0 the prescaler holds its value and no tick occurs.
  - A write to TL clears the prescaler.
- On a tick:
  - If TL == 0xFFFF_FFFF: TL <= TH (overflow), and if IE=1, ST <= 1.
  - Otherwise: TL <= TL + 1.
  - Arithmetic is unsigned 32-bit.
- Overflow occurs on the tick at 0xFFFF_FFFF. The reload value TH is held for one tick period before counting resumes, so with PRESCALE=1 the period is 2^32 - TH cycles.
- ST is cleared only by a software write of TCON with bit2=0. Writing bit2=1 sets it (software-raised interrupt).
- Writes are registered: the new value is visible to reads from the next cycle. Reads return pre-edge state.
- Simultaneous events:
  - TL write and a tick in the same cycle: the write wins and the tick is dropped.
  - TCON write clearing ST in the same cycle as an overflow with IE=1: ST ends at 1. Interrupts are never lost.
  - TCON write to EN/IE in the same cycle as an overflow: the overflow's IE test uses the pre-write IE.
  - mem_read and mem_write both high: the write is performed and rdata shows pre-write state.
- irq is level: it stays high until the handler clears ST. Masking during the handler is done by the CPU's Supervised bit, not by this block.

Decomposition:
- Shared package/header holds:
  - Offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_CYC, OFF_PEND.
  - TCON bit indices: EN_BIT, IE_BIT, ST_BIT.
  - The default BASE_ADDR.
- One natural sub-module, timer_prescaler: counter, tick output, sync clear.
- Address decode, register file and IRQ logic stay in the top.

Test Plan:
1. Reset, then read all five offsets → TH=TL=TCON=0. CYC counts 1,2,3 on consecutive post-reset cycles. irq=0. Address 0x4000_0014 gives hit=0 and rdata=0.
2. PRESCALE=1. Write TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 → TL reads FFFF_FFFF, then FFFF_FFFC. irq rises the same edge TL reloads. Subsequent overflows occur every 4 cycles.
3. irq high, then write TCON=3 → irq low next cycle. Repeat with the write landing on the overflow cycle → irq stays 1.
4. PRESCALE=4, TL=0, EN=1 → TL increments once per 4 cycles. Clearing EN holds TL and the prescaler. Re-enabling resumes the same phase.
5. Write TL=0x10 on a tick cycle → TL reads 0x10 next cycle, not 0x11. Writing CYC leaves it unchanged.
6. Counting with irq=1, then assert reset for 1 cycle → all registers 0, irq=0 on the next cycle, and CYC restarts from 0.
